uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock, `TX_CLK`, and an asynchronous active-low reset, `RST`.
REQ-002 The block SHALL have these ports:
- `TX_CLK`, input, 1 bit: bit-rate clock; one serial bit per cycle.
- `RST`, input, 1 bit: asynchronous active-low reset.
- `P_DATA`, input, 8 bits: parallel byte to transmit.
- `DATA_VALID`, input, 1 bit: request to transmit `P_DATA`.
- `PAR_EN`, input, 1 bit: 1 = insert parity bit.
- `PAR_TYP`, input, 1 bit: 0 = even parity, 1 = odd parity.
- `TX_OUT`, output, 1 bit: serial line, idles high; registered.
- `Busy`, output, 1 bit: frame in progress; registered.

Function
REQ-003 The frame SHALL be sent in this order:
- start bit (0);
- `P_DATA[0]` through `P_DATA[7]`, LSB first;
- optional parity bit;
- stop bit (1).
REQ-004 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with these transitions:
- IDLE→START on accept;
- START→DATA;
- DATA→PARITY after 8 bits when parity is enabled, else DATA→STOP;
- PARITY→STOP;
- STOP→IDLE, or STOP→START on back-to-back accept.
REQ-005 An accept SHALL occur at a rising edge where `DATA_VALID`=1 and the state is IDLE or STOP.
REQ-006 At an accept edge, the block SHALL latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers.
REQ-007 Changes to `P_DATA`, `PAR_EN` and `PAR_TYP` after the accept edge SHALL NOT affect the frame in flight.
REQ-008 `DATA_VALID` SHALL be ignored in START, DATA and PARITY; the request is dropped, not queued.
REQ-009 `TX_OUT` SHALL present each frame bit for exactly one `TX_CLK` cycle.
REQ-010 The start bit SHALL appear in the cycle immediately following the accept edge, giving zero-cycle added latency.
REQ-011 A 3-bit counter SHALL index data bits 0..7; it SHALL reset to 0 on entry to DATA and SHALL never wrap mid-byte.
REQ-012 The parity bit SHALL be the XOR of the 8 latched data bits when `PAR_TYP`=0, and its inverse when `PAR_TYP`=1.
REQ-013 `Busy` SHALL be 1 from the accept edge through the last stop-bit cycle, and 0 only in IDLE.
REQ-014 A frame SHALL hold `Busy` high for 10 cycles without parity and 11 cycles with parity.
REQ-015 A back-to-back accept in STOP SHALL follow the stop bit directly with the next start bit: no idle gap, and `Busy` stays 1.
REQ-016 `TX_OUT` SHALL be 1 in IDLE.

Reset
REQ-017 `RST`=0 SHALL immediately force state IDLE, `TX_OUT`=1, `Busy`=0, bit counter 0, and latched data/parity registers 0, independent of `TX_CLK`.
REQ-018 Reset asserted mid-frame SHALL abort the frame with no resumption, and the line SHALL return high immediately.
REQ-019 After `RST` deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-020 With macro `UART_TX_PARITY_EN` defined, the block SHALL implement the PARITY state and honour `PAR_EN`/`PAR_TYP` per REQ-004 and REQ-012.
REQ-021 Without `UART_TX_PARITY_EN`, the PARITY state and parity logic SHALL be absent.
REQ-022 Without `UART_TX_PARITY_EN`, the `PAR_EN`/`PAR_TYP` ports SHALL remain but be ignored, and every frame SHALL be 10 bits.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- `P_DATA`=0xA5, `PAR_EN`=0 → `TX_OUT`=0,1,0,1,0,0,1,0,1,1; `Busy` high 10 cycles.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 → parity bit 0; `PAR_TYP`=1 → parity bit 1; `Busy` high 11 cycles.
- `P_DATA`=0x01, `PAR_EN`=1, even, then `DATA_VALID` held through the STOP cycle with `P_DATA`=0x80 → second start bit in the cycle after the stop bit; no idle cycle; `Busy` continuous 22 cycles.
- `DATA_VALID` pulsed with 0x3C during DATA of a 0xFF frame → ignored; the 0xFF frame completes unchanged; return to IDLE with `TX_OUT`=1.
- `RST` asserted during data bit 4 of 0x00 → `TX_OUT`=1 and `Busy`=0 without a clock edge; the next accept of 0x55 yields a clean full frame.
- Build without `UART_TX_PARITY_EN`, `PAR_EN`=1, 0xA5 → 10-bit frame identical to scenario 1.

Source files
------------

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- parallel-side bundle for the uart_tx serialiser.
//
// Signals:
//   P_DATA     [7:0] byte to transmit (master -> slave)
//   DATA_VALID       transmit request (master -> slave)
//   PAR_EN           1 = append parity bit (master -> slave)
//   PAR_TYP          0 = even, 1 = odd parity (master -> slave)
//   TX_OUT           serial line, idles high (slave -> master)
//   Busy             frame in progress (slave -> master)
//
// Modports: master (the byte producer / bench), slave (uart_tx).
// -----------------------------------------------------------------------------
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART frame serialiser, one serial bit per TX_CLK cycle.
//
// Frame: start(0), P_DATA[0..7] LSB first, optional parity, stop(1).
//
// Ports:
//   TX_CLK  bit-rate clock
//   RST     asynchronous active-low reset
//   bus     uart_tx_if.slave: P_DATA, DATA_VALID, PAR_EN, PAR_TYP in;
//           TX_OUT, Busy out (both registered)
//
// Build option: define UART_TX_PARITY_EN to include the PARITY state and
// honour PAR_EN / PAR_TYP. Without it, those inputs are ignored and every
// frame is 10 bits long.
// -----------------------------------------------------------------------------
module uart_tx (
  input  logic     TX_CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0] state_reg, state_next;
  logic [2:0] cnt_reg,   cnt_next;
  logic [7:0] data_reg,  data_next;
  logic       tx_reg,    tx_next;
  logic       busy_reg,  busy_next;
  logic       accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_reg,  par_en_next;
  logic par_typ_reg, par_typ_next;
  logic parity_bit;

  // Even parity is the plain XOR of the latched byte; odd inverts it.
  assign parity_bit = (^data_reg) ^ par_typ_reg;
`else
  logic unused_par;
  assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  // A request is only taken when the line is idle or finishing a stop bit;
  // anywhere else it is simply dropped.
  assign accept = bus.DATA_VALID && ((state_reg == IDLE) || (state_reg == STOP));

  // tx_next is the bit that will be on the line during the state being
  // entered, so TX_OUT is registered and the start bit follows the accept
  // edge with no extra latency.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    tx_next    = tx_reg;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;
`endif

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
      end
      START: begin
        state_next = DATA;
        cnt_next   = 3'd0;
        tx_next    = data_reg[0];
      end
      DATA: begin
        if (cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_reg) begin
            state_next = PARITY;
            tx_next    = parity_bit;
          end else begin
            state_next = STOP;
            tx_next    = 1'b1;
          end
`else
          state_next = STOP;
          tx_next    = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + 3'd1;
          tx_next  = data_reg[cnt_reg + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_next = STOP;
        tx_next    = 1'b1;
      end
`endif
      STOP: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Accept overrides the IDLE/STOP defaults: in STOP this chains the next
    // start bit directly behind the stop bit.
    if (accept) begin
      state_next = START;
      tx_next    = 1'b0;
      data_next  = bus.P_DATA;
`ifdef UART_TX_PARITY_EN
      par_en_next  = bus.PAR_EN;
      par_typ_next = bus.PAR_TYP;
`endif
    end
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge TX_CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      data_reg  <= 8'h00;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
`endif
    end
  end

  assign bus.TX_OUT = tx_reg;
  assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx.
// Expected line sequences are written in time order: sample i of an N-sample
// window is bit [N-1-i] of the literal. Sample 0 is the cycle right after the
// accept edge. Works for builds with and without UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic tx_s   [0:31];
  logic busy_s [0:31];

  uart_tx_if bus ();

  uart_tx dut (
    .TX_CLK (clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam int          PAR_N      = 13;
  localparam logic [23:0] PAR_EVEN   = 24'b0101001010111;
  localparam logic [23:0] PAR_ODD    = 24'b0101001011111;
  localparam logic [23:0] PAR_BUSY   = 24'b1111111111100;
  localparam int          B2B_N      = 24;
  localparam int          B2B_SECOND = 11;
  localparam logic [23:0] B2B_TX     = 24'b010000000110000000011111;
  localparam logic [23:0] B2B_BUSY   = 24'b111111111111111111111100;
`else
  localparam int          PAR_N      = 13;
  localparam logic [23:0] PAR_EVEN   = 24'b0101001011111;
  localparam logic [23:0] PAR_ODD    = 24'b0101001011111;
  localparam logic [23:0] PAR_BUSY   = 24'b1111111111000;
  localparam int          B2B_N      = 22;
  localparam int          B2B_SECOND = 10;
  localparam logic [23:0] B2B_TX     = 24'b0100000001000000001111;
  localparam logic [23:0] B2B_BUSY   = 24'b1111111111111111111100;
`endif

  task automatic test_reset();
    rst = 1'b0;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA = 8'h00;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx got=%b want=1", bus.TX_OUT);
    end
    checks++;
    if (bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.Busy);
    end
    // Release reset together with a request: first rising edge must accept.
    rst = 1'b1;
    bus.P_DATA = 8'h01;
    bus.DATA_VALID = 1'b1;
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    checks++;
    if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL first_accept tx=%b busy=%b want tx=0 busy=1", bus.TX_OUT, bus.Busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL first_frame_idle tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_no_parity();
    logic [11:0] e_tx   = 12'b010100101111;
    logic [11:0] e_busy = 12'b111111111100;
    @(negedge clk);
    bus.P_DATA = 8'hA5;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tx_s[i] = bus.TX_OUT;
      busy_s[i] = bus.Busy;
      if (i == 0) bus.DATA_VALID = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tx_s[i] !== e_tx[11-i] || busy_s[i] !== e_busy[11-i]) begin
        failures++;
        $display("FAIL a5_nopar[%0d] tx=%b busy=%b want tx=%b busy=%b",
                 i, tx_s[i], busy_s[i], e_tx[11-i], e_busy[11-i]);
      end
    end
    $display("test_no_parity 0xA5 done checks=%0d", checks);
  endtask

  task automatic test_parity();
    logic [23:0] e_tx;
    for (int pt = 0; pt < 2; pt++) begin
      e_tx = (pt == 0) ? PAR_EVEN : PAR_ODD;
      @(negedge clk);
      bus.P_DATA = 8'hA5;
      bus.PAR_EN = 1'b1;
      bus.PAR_TYP = pt[0];
      bus.DATA_VALID = 1'b1;
      for (int i = 0; i < PAR_N; i++) begin
        @(negedge clk);
        tx_s[i] = bus.TX_OUT;
        busy_s[i] = bus.Busy;
        if (i == 0) begin
          // Scramble the inputs: the frame in flight must not notice.
          bus.DATA_VALID = 1'b0;
          bus.P_DATA = 8'h00;
          bus.PAR_EN = 1'b0;
          bus.PAR_TYP = ~pt[0];
        end
      end
      for (int i = 0; i < PAR_N; i++) begin
        checks++;
        if (tx_s[i] !== e_tx[PAR_N-1-i] || busy_s[i] !== PAR_BUSY[PAR_N-1-i]) begin
          failures++;
          $display("FAIL a5_par_typ%0d[%0d] tx=%b busy=%b want tx=%b busy=%b",
                   pt, i, tx_s[i], busy_s[i], e_tx[PAR_N-1-i], PAR_BUSY[PAR_N-1-i]);
        end
      end
      $display("test_parity 0xA5 typ=%0d done checks=%0d", pt, checks);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.P_DATA = 8'h01;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < B2B_N; i++) begin
      @(negedge clk);
      tx_s[i] = bus.TX_OUT;
      busy_s[i] = bus.Busy;
      if (i == 0) begin
        bus.DATA_VALID = 1'b0;
        bus.P_DATA = 8'h80;
      end
      // Raised during the last data bit and held through STOP; only the
      // STOP-cycle edge may take it.
      if (i == 8) bus.DATA_VALID = 1'b1;
      if (i == B2B_SECOND) bus.DATA_VALID = 1'b0;
    end
    for (int i = 0; i < B2B_N; i++) begin
      checks++;
      if (tx_s[i] !== B2B_TX[B2B_N-1-i] || busy_s[i] !== B2B_BUSY[B2B_N-1-i]) begin
        failures++;
        $display("FAIL b2b[%0d] tx=%b busy=%b want tx=%b busy=%b",
                 i, tx_s[i], busy_s[i], B2B_TX[B2B_N-1-i], B2B_BUSY[B2B_N-1-i]);
      end
    end
    $display("test_back_to_back 0x01/0x80 done checks=%0d", checks);
  endtask

  task automatic test_ignore_in_data();
    logic [11:0] e_tx   = 12'b011111111111;
    logic [11:0] e_busy = 12'b111111111100;
    @(negedge clk);
    bus.P_DATA = 8'hFF;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tx_s[i] = bus.TX_OUT;
      busy_s[i] = bus.Busy;
      if (i == 0) bus.DATA_VALID = 1'b0;
      if (i == 3) begin
        bus.P_DATA = 8'h3C;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 4) bus.DATA_VALID = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tx_s[i] !== e_tx[11-i] || busy_s[i] !== e_busy[11-i]) begin
        failures++;
        $display("FAIL ignore_ff[%0d] tx=%b busy=%b want tx=%b busy=%b",
                 i, tx_s[i], busy_s[i], e_tx[11-i], e_busy[11-i]);
      end
    end
    $display("test_ignore_in_data 0xFF done checks=%0d", checks);
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] e_tx   = 12'b010101010111;
    logic [11:0] e_busy = 12'b111111111100;
    @(negedge clk);
    bus.P_DATA = 8'h00;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    // Samples 0..5: start bit then data bits 0..4, all low, Busy high.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) bus.DATA_VALID = 1'b0;
      checks++;
      if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL zero_frame[%0d] tx=%b busy=%b want tx=0 busy=1", i, bus.TX_OUT, bus.Busy);
      end
    end
    // Now mid data bit 4, half a cycle from the next rising edge.
    rst = 1'b0;
    #1;
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    @(negedge clk);
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    rst = 1'b1;
    bus.P_DATA = 8'h55;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tx_s[i] = bus.TX_OUT;
      busy_s[i] = bus.Busy;
      if (i == 0) bus.DATA_VALID = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tx_s[i] !== e_tx[11-i] || busy_s[i] !== e_busy[11-i]) begin
        failures++;
        $display("FAIL after_reset_55[%0d] tx=%b busy=%b want tx=%b busy=%b",
                 i, tx_s[i], busy_s[i], e_tx[11-i], e_busy[11-i]);
      end
    end
    $display("test_reset_mid_frame 0x00/0x55 done checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_ignore_in_data();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
